// File: rtl/uart_tx_ctrl_if.sv
// ============================================================================
// Module   : uart_tx_ctrl_if
// Purpose  : Bundles the register bus from the core and the byte handshake
//            to the UART transmitter for uart_tx_ctrl.
// Ports    : master - core / transmitter side (drives writes and tx_done)
//            slave  - uart_tx_ctrl side (drives rd_data, dvsr, tx_data,
//                     tx_start, busy)
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface uart_tx_ctrl_if #(
  parameter int DVSR_W = 11
);
  // Register bus
  logic              write_enable;
  logic [4:0]        address;
  logic [31:0]       data_in;
  logic [31:0]       rd_data;
  // Transmitter handshake
  logic [DVSR_W-1:0] dvsr;
  logic [7:0]        tx_data;
  logic              tx_start;
  logic              tx_done;
  logic              busy;

  modport master (
    output write_enable, address, data_in, tx_done,
    input  rd_data, dvsr, tx_data, tx_start, busy
  );

  modport slave (
    input  write_enable, address, data_in, tx_done,
    output rd_data, dvsr, tx_data, tx_start, busy
  );
endinterface

`default_nettype wire

// File: rtl/uart_tx_ctrl.sv
// ============================================================================
// Module   : uart_tx_ctrl
// Purpose  : UART transmit sequencer. Decodes register writes, buffers bytes
//            in a FIFO, holds the baud divisor and hands bytes one at a time
//            to the transmitter with a one-cycle tx_start pulse, waiting for
//            tx_done before the next.
// Ports    : clk    - system clock, rising edge
//            rst_n  - asynchronous active-low reset
//            bus    - uart_tx_ctrl_if.slave (register bus + tx handshake)
//            irq    - interrupt, only when UART_TX_IRQ_EN is defined
// Options  : UART_TX_IRQ_EN - adds the irq port and the CTRL.IRQEN bit
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module uart_tx_ctrl #(
  parameter int FIFO_DEPTH = 8,
  parameter int DVSR_W     = 11
) (
  input  logic           clk,
  input  logic           rst_n,
  uart_tx_ctrl_if.slave  bus
`ifdef UART_TX_IRQ_EN
  ,
  output logic           irq
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [2:0] C_IDX_TXDATA = 3'd0;
  localparam logic [2:0] C_IDX_DVSR   = 3'd1;
  localparam logic [2:0] C_IDX_CTRL   = 3'd2;
  localparam logic [2:0] C_IDX_STATUS = 3'd3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_START = 2'd2,
    S_WAIT  = 2'd3
  } state_t;

  state_t            r_state;
  logic [7:0]        r_mem [FIFO_DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              r_en;
  logic              r_ovf;
  logic              r_busy;
  logic              r_tx_start;
  logic [7:0]        r_tx_data;
  logic [DVSR_W-1:0] r_dvsr;

  logic [2:0]        w_idx;
  logic              w_wr_txdata;
  logic              w_wr_dvsr;
  logic              w_wr_ctrl;
  logic              w_full;
  logic              w_empty;
  logic              w_flush;
  logic              w_pop;
  logic              w_push;
  logic              w_drop;
  logic              w_can_load;
  logic              w_irqen;
  logic [31:0]       w_rd_data;
  logic              w_unused_bits;

  // --------------------------------------------------------------------------
  // Register decode
  // --------------------------------------------------------------------------
  assign w_idx       = bus.address[4:2];
  assign w_wr_txdata = bus.write_enable && (w_idx == C_IDX_TXDATA);
  assign w_wr_dvsr   = bus.write_enable && (w_idx == C_IDX_DVSR);
  assign w_wr_ctrl   = bus.write_enable && (w_idx == C_IDX_CTRL);
  assign w_flush     = w_wr_ctrl && bus.data_in[1];

  // Byte-lane bits and upper data bits are not decoded by every register.
  assign w_unused_bits = ^{bus.address[1:0], bus.data_in};

  // --------------------------------------------------------------------------
  // FIFO
  // --------------------------------------------------------------------------
  assign w_full  = (r_count == CW'(FIFO_DEPTH));
  assign w_empty = (r_count == '0);

  // The FSM only enters LOAD with a non-empty FIFO; the guard keeps the
  // pointers consistent regardless.
  assign w_pop  = (r_state == S_LOAD) && !w_empty;
  // A pop in the same cycle frees a slot, so a push into a full FIFO is
  // still accepted then.
  assign w_push = w_wr_txdata && (!w_full || w_pop);
  assign w_drop = w_wr_txdata && w_full && !w_pop;

  // A flush landing on the same edge must not send the FSM into LOAD with
  // a FIFO that is about to be emptied.
  assign w_can_load = r_en && !w_empty && !w_flush;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= bus.data_in[7:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (w_flush) begin
      // A flush in LOAD still lets that cycle's pop reach tx_data; only the
      // remaining contents are discarded.
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Control / divisor registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dvsr <= '0;
      r_en   <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      if (w_wr_dvsr) begin
        r_dvsr <= bus.data_in[DVSR_W-1:0];
      end
      if (w_wr_ctrl) begin
        r_en <= bus.data_in[0];
      end
      if (w_wr_ctrl && bus.data_in[2]) begin
        r_ovf <= 1'b0;
      end else if (w_drop) begin
        r_ovf <= 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Sequencer. tx_start and busy are registered alongside the state so they
  // line up with START and with LOAD/START/WAIT respectively.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_busy     <= 1'b0;
      r_tx_start <= 1'b0;
      r_tx_data  <= 8'h00;
    end else begin
      r_tx_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_can_load) begin
            r_state <= S_LOAD;
            r_busy  <= 1'b1;
          end
        end
        S_LOAD: begin
          r_tx_data  <= r_mem[r_rd_ptr];
          r_tx_start <= 1'b1;
          r_state    <= S_START;
        end
        S_START: begin
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.tx_done) begin
            if (w_can_load) begin
              r_state <= S_LOAD;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Optional interrupt
  // --------------------------------------------------------------------------
`ifdef UART_TX_IRQ_EN
  logic r_irqen;
  logic r_irq;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_irqen <= 1'b0;
      r_irq   <= 1'b0;
    end else begin
      if (w_wr_ctrl) begin
        r_irqen <= bus.data_in[3];
      end
      r_irq <= r_irqen && w_empty && (r_state == S_IDLE);
    end
  end

  assign w_irqen = r_irqen;
  assign irq     = r_irq;
`else
  assign w_irqen = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Read mux (no side effects)
  // --------------------------------------------------------------------------
  always_comb begin
    w_rd_data = '0;
    case (w_idx)
      C_IDX_DVSR: begin
        w_rd_data = 32'(r_dvsr);
      end
      C_IDX_CTRL: begin
        w_rd_data[0] = r_en;
        w_rd_data[3] = w_irqen;
      end
      C_IDX_STATUS: begin
        w_rd_data[0]      = w_full;
        w_rd_data[1]      = w_empty;
        w_rd_data[2]      = r_busy;
        w_rd_data[3]      = r_ovf;
        w_rd_data[8 +: CW] = r_count;
      end
      default: begin
        w_rd_data = '0;
      end
    endcase
  end

  assign bus.rd_data  = w_rd_data;
  assign bus.dvsr     = r_dvsr;
  assign bus.tx_data  = r_tx_data;
  assign bus.tx_start = r_tx_start;
  assign bus.busy     = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_ctrl.sv
// ============================================================================
// Module   : tb_uart_tx_ctrl
// Purpose  : Self-checking bench for uart_tx_ctrl. Random byte payloads and
//            frame lengths are checked against a queue model of the FIFO and
//            the timing rules of the controller.
// Options  : UART_TX_IRQ_EN - also exercises the irq output
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uart_tx_ctrl;

  localparam int FIFO_DEPTH = 8;
  localparam int DVSR_W     = 11;

  localparam logic [4:0] A_TXDATA = 5'h00;
  localparam logic [4:0] A_DVSR   = 5'h04;
  localparam logic [4:0] A_CTRL   = 5'h08;
  localparam logic [4:0] A_STATUS = 5'h0C;
  localparam logic [4:0] A_RSVD6  = 5'h18;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  uart_tx_ctrl_if #(.DVSR_W(DVSR_W)) bus ();
`ifdef UART_TX_IRQ_EN
  logic irq;
`endif

  uart_tx_ctrl #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .DVSR_W     (DVSR_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef UART_TX_IRQ_EN
    ,
    .irq   (irq)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: bytes currently held in the FIFO, in order, and the
  // sticky overflow flag.
  logic [7:0] model_q [$];
  logic       model_ovf = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_status(input logic busy_e);
    logic [31:0] s;
    int          n;
    n     = model_q.size();
    s     = '0;
    s[0]  = (n == FIFO_DEPTH);
    s[1]  = (n == 0);
    s[2]  = busy_e;
    s[3]  = model_ovf;
    s[11:8] = n[3:0];
    return s;
  endfunction

  // Called at a falling edge; the write is sampled on the next rising edge
  // and the task returns on the falling edge that follows it.
  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    bus.write_enable = 1'b1;
    bus.address      = a;
    bus.data_in      = d;
    @(negedge clk);
    bus.write_enable = 1'b0;
    bus.address      = A_STATUS;
    bus.data_in      = '0;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    bus.address = a;
    #1;
    d = bus.rd_data;
    bus.address = A_STATUS;
  endtask

  // Push with EN=0: the model applies the full/drop rule.
  task automatic push(input logic [7:0] b);
    wr(A_TXDATA, {24'h0, b});
    if (model_q.size() < FIFO_DEPTH) model_q.push_back(b);
    else model_ovf = 1'b1;
  endtask

  task automatic pulse_done();
    bus.tx_done = 1'b1;
    @(negedge clk);
    bus.tx_done = 1'b0;
  endtask

  // Returns the number of rising edges until tx_start is seen, or -1.
  task automatic wait_start(input int limit, output int n);
    int i;
    n = -1;
    i = 0;
    while (n < 0 && i < limit) begin
      @(negedge clk);
      i++;
      if (bus.tx_start === 1'b1) n = i;
    end
  endtask

  // Transmitter model: hold the frame for a random time, then tx_done.
  task automatic end_frame();
    int d;
    d = int'($urandom_range(1, 20));
    repeat (d) @(negedge clk);
    check("busy_in_frame", 32'(bus.busy), 32'd1);
    pulse_done();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    logic [31:0] r;
    logic [7:0]  b;
    logic [7:0]  exp_b;
    int          n;

    bus.write_enable = 1'b0;
    bus.address      = A_STATUS;
    bus.data_in      = '0;
    bus.tx_done      = 1'b0;

    // ---------------- Reset values ----------------
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_tx_start", 32'(bus.tx_start), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_dvsr", 32'(bus.dvsr), 32'd0);
    check("rst_tx_data", 32'(bus.tx_data), 32'd0);
    rd(A_STATUS, r); check("rst_status", r, 32'h0000_0002);
    rd(A_CTRL, r);   check("rst_ctrl", r, 32'h0);
    rd(A_TXDATA, r); check("rd_txdata_zero", r, 32'h0);
`ifdef UART_TX_IRQ_EN
    check("rst_irq", 32'(irq), 32'd0);
`endif

    // ---------------- Divisor and register map ----------------
    v = $urandom;
    wr(A_DVSR, v);
    check("dvsr_port", 32'(bus.dvsr), v & 32'h7FF);
    rd(A_DVSR, r); check("dvsr_read", r, v & 32'h7FF);
    wr(A_DVSR, 32'h145);
    check("dvsr_145", 32'(bus.dvsr), 32'h145);
    wr(A_STATUS, 32'hFFFF_FFFF);
    rd(A_STATUS, r); check("status_write_ignored", r, 32'h0000_0002);
    wr(A_RSVD6, $urandom);
    rd(A_RSVD6, r); check("rsvd_read_zero", r, 32'h0);
    // FLUSH and OVFCLR read back 0; IRQEN only exists with the option.
    wr(A_CTRL, 32'hF);
`ifdef UART_TX_IRQ_EN
    rd(A_CTRL, r); check("ctrl_read", r, 32'h9);
`else
    rd(A_CTRL, r); check("ctrl_read", r, 32'h1);
`endif
    wr(A_CTRL, 32'h0);
    // tx_done outside WAIT has no effect.
    pulse_done();
    wait_start(5, n);
    check("done_idle_ignored", 32'(n), 32'hFFFF_FFFF);
    check("done_idle_busy", 32'(bus.busy), 32'd0);

    // ---------------- Single byte ----------------
    wr(A_CTRL, 32'h1);
    wr(A_TXDATA, 32'hA5);
    check("single_busy_e0", 32'(bus.busy), 32'd0);
    wait_start(10, n);
    check("single_latency", 32'(n), 32'd2);
    check("single_data", 32'(bus.tx_data), 32'hA5);
    @(negedge clk);
    check("single_pulse_width", 32'(bus.tx_start), 32'd0);
    end_frame();
    check("single_busy_end", 32'(bus.busy), 32'd0);
    rd(A_STATUS, r); check("single_status_end", r, exp_status(1'b0));

    // ---------------- Burst, including push+pop on a full FIFO ----------------
    wr(A_CTRL, 32'h0);
    for (int i = 0; i < FIFO_DEPTH; i++) push(8'($urandom));
    rd(A_STATUS, r); check("burst_full", r, exp_status(1'b0));
    wr(A_CTRL, 32'h1);      // IDLE sees EN on the next edge
    @(negedge clk);         // now in LOAD: the next edge pops the head
    b = 8'($urandom);
    exp_b = model_q.pop_front();
    wr(A_TXDATA, {24'h0, b});
    model_q.push_back(b);
    check("burst_first_start", 32'(bus.tx_start), 32'd1);
    check("burst_first_data", 32'(bus.tx_data), 32'(exp_b));
    rd(A_STATUS, r); check("burst_pushpop_full", r, exp_status(1'b1));
    while (model_q.size() > 0) begin
      end_frame();
      wait_start(10, n);
      // The tx_done edge itself is the first of the two edges.
      check("burst_spacing", 32'(n + 1), 32'd2);
      exp_b = model_q.pop_front();
      check("burst_order", 32'(bus.tx_data), 32'(exp_b));
    end
    end_frame();
    check("burst_idle_busy", 32'(bus.busy), 32'd0);
    rd(A_STATUS, r); check("burst_idle_status", r, exp_status(1'b0));

    // ---------------- Overflow ----------------
    wr(A_CTRL, 32'h0);
    for (int i = 0; i < FIFO_DEPTH + 1; i++) push(8'($urandom));
    rd(A_STATUS, r); check("ovf_status", r, exp_status(1'b0));
    check("ovf_status_abs", r, 32'h0000_0809);
    wr(A_CTRL, 32'h4);
    model_ovf = 1'b0;
    rd(A_STATUS, r); check("ovfclr_status", r, exp_status(1'b0));
    wr(A_CTRL, 32'h1);
    wait_start(10, n);
    check("ovf_en_latency", 32'(n), 32'd2);
    exp_b = model_q.pop_front();
    check("ovf_order", 32'(bus.tx_data), 32'(exp_b));
    while (model_q.size() > 0) begin
      end_frame();
      wait_start(10, n);
      check("ovf_spacing", 32'(n + 1), 32'd2);
      exp_b = model_q.pop_front();
      check("ovf_order", 32'(bus.tx_data), 32'(exp_b));
    end
    end_frame();
    wait_start(10, n);
    check("ovf_ninth_dropped", 32'(n), 32'hFFFF_FFFF);

    // ---------------- Flush / disable mid-frame ----------------
    wr(A_CTRL, 32'h0);
    for (int i = 0; i < 4; i++) push(8'($urandom));
    wr(A_CTRL, 32'h1);
    wait_start(10, n);
    check("flush_latency", 32'(n), 32'd2);
    exp_b = model_q.pop_front();
    check("flush_first_data", 32'(bus.tx_data), 32'(exp_b));
    @(negedge clk);         // WAIT
    wr(A_CTRL, 32'h2);
    model_q.delete();
    rd(A_STATUS, r); check("flush_status_wait", r, exp_status(1'b1));
    check("flush_tx_data_kept", 32'(bus.tx_data), 32'(exp_b));
    end_frame();
    check("flush_busy_end", 32'(bus.busy), 32'd0);
    wait_start(10, n);
    check("flush_no_more_start", 32'(n), 32'hFFFF_FFFF);

    // ---------------- Reset mid-WAIT ----------------
    wr(A_CTRL, 32'h0);
    for (int i = 0; i < 3; i++) push(8'($urandom));
    wr(A_CTRL, 32'h1);
    wait_start(10, n);
    check("rstw_latency", 32'(n), 32'd2);
    @(negedge clk);         // WAIT
    rst_n = 1'b0;
    model_q.delete();
    model_ovf = 1'b0;
    #1;
    check("rstw_tx_start", 32'(bus.tx_start), 32'd0);
    check("rstw_busy", 32'(bus.busy), 32'd0);
    check("rstw_dvsr", 32'(bus.dvsr), 32'd0);
    rd(A_STATUS, r); check("rstw_status", r, 32'h0000_0002);
    @(negedge clk);
    rst_n = 1'b1;
    wait_start(10, n);
    check("rstw_fifo_lost", 32'(n), 32'hFFFF_FFFF);

`ifdef UART_TX_IRQ_EN
    // ---------------- Interrupt ----------------
    wr(A_CTRL, 32'h9);
    check("irq_pre", 32'(irq), 32'd0);
    @(negedge clk);
    check("irq_idle_empty", 32'(irq), 32'd1);
    b = 8'($urandom);
    wr(A_TXDATA, {24'h0, b});
    @(negedge clk);
    check("irq_drop_on_push", 32'(irq), 32'd0);
    wait_start(10, n);
    check("irq_byte", 32'(bus.tx_data), 32'(b));
    end_frame();
    check("irq_low_at_idle", 32'(irq), 32'd0);
    @(negedge clk);
    check("irq_rise", 32'(irq), 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
